dcache_data_memory: RTL

//  Responder side of the data-cache <-> data-memory line interface: a 256-bit/line

---
 rtl/dcache_data_memory.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dcache_data_memory.sv
// dcache_data_memory: 256-bit/line backing store answering dcache fills and writebacks.
// Latency: ack_o pulses LATENCY cycles after the accepting edge; one request outstanding.
// Backpressure: enable_i held until ack_o; a dead cycle follows each ack. Option: DMEM_STATS_EN.
module dcache_data_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int IDX_W   = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]  rd_cnt_o,
    output logic [15:0]  wr_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK,
        S_GAP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic               accept;
    logic               enter_ack;

    logic               req_write;
    logic [IDX_W-1:0]   req_idx;
    logic [255:0]       req_dat;

    logic [255:0]       mem [DEPTH];

    // Byte offset and high address bits never select a line; addresses wrap modulo DEPTH.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[4:0], addr_i[31:5+IDX_W]};

    // The counter is loaded with LATENCY so the ACK entry edge lands exactly LATENCY edges
    // after acceptance, which also covers LATENCY=1 with a single BUSY cycle.
    assign enter_ack = (state_q == S_BUSY) && (cnt_q == 8'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    accept  = 1'b1;
                    cnt_d   = 8'(LATENCY);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            S_ACK:   state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= (state_d == S_ACK);
            if (enter_ack) begin
                data_o <= req_write ? req_dat : mem[req_idx];
            end
        end
    end

    // Request copy is held through BUSY so the dcache may drop or change its inputs.
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            req_write <= write_i;
            req_idx   <= addr_i[5 +: IDX_W];
            req_dat   <= data_i;
        end
    end

    // Commit happens only on ACK entry, so a reset during BUSY discards the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_ack && req_write) begin
            mem[req_idx] <= req_dat;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_o <= 16'd0;
            wr_cnt_o <= 16'd0;
        end else if (enter_ack) begin
            if (req_write) begin
                wr_cnt_o <= wr_cnt_o + 16'd1;
            end else begin
                rd_cnt_o <= rd_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
